// File: rtl/tf_lane_seq_gen_if.sv
// Bus bundle for tf_lane_seq_gen: table config, run control, stage gating and the
// multi-lane twiddle output stream. master drives config/control, slave is the sequencer.
interface tf_lane_seq_gen_if #(
   parameter int P_WIDTH  = 64,
   parameter int ADDR_W   = 6,
   parameter int LANES    = 4,
   parameter int HOLD_W   = 4,
   parameter int SC_WIDTH = 3
);
   logic                     cfg_we;
   logic [ADDR_W-1:0]        cfg_addr;
   logic [P_WIDTH-1:0]       cfg_wdata;
   logic                     start;
   logic [ADDR_W-1:0]        start_idx;
   logic [HOLD_W-1:0]        hold_len;
   logic [ADDR_W:0]          num_idx;
   logic [SC_WIDTH-1:0]      stage_counter;
   logic                     CEN;
   logic                     busy;
   logic                     tf_valid;
   logic [LANES*P_WIDTH-1:0] tf_data;
   logic                     done;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, start, start_idx, hold_len, num_idx,
             stage_counter, CEN,
      input  busy, tf_valid, tf_data, done
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, start, start_idx, hold_len, num_idx,
             stage_counter, CEN,
      output busy, tf_valid, tf_data, done
   );
endinterface

// File: rtl/tf_lane_seq_gen.sv
// Twiddle-factor sequencer: runtime-loaded table streamed LANES words per beat, each index
// held hold_len+1 beats. Optional macro TF_UNITY_LANE0_EN forces lane 0 to one.
module tf_lane_seq_gen #(
   parameter int P_WIDTH      = 64,
   parameter int DEPTH        = 64,
   parameter int ADDR_W       = 6,
   parameter int LANES        = 4,
   parameter int LANE_STRIDE  = 16,
   parameter int HOLD_W       = 4,
   parameter int SC_WIDTH     = 3,
   parameter int ACTIVE_STAGE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   tf_lane_seq_gen_if.slave bus
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [ADDR_W:0]   REM_ONE   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   REM_ZERO  = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0]   REM_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] IDX_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [HOLD_W-1:0] CNT_ONE   = {{(HOLD_W-1){1'b0}}, 1'b1};
   localparam logic [HOLD_W-1:0] CNT_ZERO  = {HOLD_W{1'b0}};
   localparam logic [SC_WIDTH-1:0] STAGE_SEL = SC_WIDTH'(ACTIVE_STAGE);

   state_t                   state_r;
   logic [P_WIDTH-1:0]       table_r [DEPTH];
   logic [ADDR_W-1:0]        idx_r;
   logic [HOLD_W-1:0]        cnt_r;
   logic [HOLD_W-1:0]        hold_r;
   logic [ADDR_W:0]          rem_r;
   logic                     busy_r;
   logic                     tf_valid_r;
   logic [LANES*P_WIDTH-1:0] tf_data_r;
   logic                     done_r;

   logic                     adv_s;
   logic [ADDR_W-1:0]        lane_addr_s [LANES];
   logic [LANES*P_WIDTH-1:0] lane_data_s;

   assign adv_s = (state_r == ST_RUN) && !bus.CEN && (bus.stage_counter == STAGE_SEL);

   // Gather one table word per lane; lane addresses wrap by ADDR_W truncation.
   always_comb begin
      lane_data_s = {(LANES*P_WIDTH){1'b0}};
      for (int l = 0; l < LANES; l++) begin
         lane_addr_s[l] = idx_r + ADDR_W'(l * LANE_STRIDE);
         lane_data_s[l*P_WIDTH +: P_WIDTH] = table_r[lane_addr_s[l]];
      end
`ifdef TF_UNITY_LANE0_EN
      lane_data_s[P_WIDTH-1:0] = {{(P_WIDTH-1){1'b0}}, 1'b1};
`else
      lane_data_s[P_WIDTH-1:0] = table_r[lane_addr_s[0]];
`endif
   end

   // Twiddle table storage; writable only while idle so a run never sees a torn table.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_r[i] <= {P_WIDTH{1'b0}};
         end
      end else if (bus.cfg_we && (state_r == ST_IDLE)) begin
         table_r[bus.cfg_addr] <= bus.cfg_wdata;
      end
   end

   // Run-control state machine with registered beat, busy and done outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         idx_r      <= {ADDR_W{1'b0}};
         cnt_r      <= CNT_ZERO;
         hold_r     <= CNT_ZERO;
         rem_r      <= REM_ZERO;
         busy_r     <= 1'b0;
         tf_valid_r <= 1'b0;
         tf_data_r  <= {(LANES*P_WIDTH){1'b0}};
         done_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               tf_valid_r <= 1'b0;
               done_r     <= 1'b0;
               if (bus.start) begin
                  state_r <= ST_RUN;
                  busy_r  <= 1'b1;
                  idx_r   <= bus.start_idx;
                  cnt_r   <= CNT_ZERO;
                  hold_r  <= bus.hold_len;
                  rem_r   <= (bus.num_idx == REM_ZERO) ? REM_DEPTH : bus.num_idx;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (adv_s) begin
                  tf_data_r  <= lane_data_s;
                  tf_valid_r <= 1'b1;
                  if (cnt_r == hold_r) begin
                     cnt_r <= CNT_ZERO;
                     idx_r <= idx_r + IDX_ONE;
                     rem_r <= rem_r - REM_ONE;
                     if (rem_r == REM_ONE) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                     end else begin
                        done_r  <= 1'b0;
                     end
                  end else begin
                     cnt_r  <= cnt_r + CNT_ONE;
                     done_r <= 1'b0;
                  end
               end else begin
                  tf_valid_r <= 1'b0;
                  done_r     <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
               tf_valid_r <= 1'b0;
               done_r     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.tf_valid = tf_valid_r;
   assign bus.tf_data  = tf_data_r;
   assign bus.done     = done_r;

endmodule

// File: tb/tb_tf_lane_seq_gen.sv
// Directed bench for tf_lane_seq_gen: table load, hold/advance, wrap, gating, DEPTH run,
// ignored writes, async reset. Expected lane 0 follows TF_UNITY_LANE0_EN when defined.
module tb_tf_lane_seq_gen;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   tf_lane_seq_gen_if #(.P_WIDTH(64), .ADDR_W(6), .LANES(4), .HOLD_W(4), .SC_WIDTH(3)) bus_if ();

   tf_lane_seq_gen #(
      .P_WIDTH(64), .DEPTH(64), .ADDR_W(6), .LANES(4), .LANE_STRIDE(16),
      .HOLD_W(4), .SC_WIDTH(3), .ACTIVE_STAGE(0)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [63:0]  tbl [64];
   logic [255:0] got [128];
   int cen_at, cen_len, stg_at, stg_len, we_at;
   logic [5:0]  we_addr;
   logic [63:0] we_data;

   task automatic check(input logic [255:0] obs, input logic [255:0] exp, input string tag);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] lane0_of(input logic [63:0] v);
`ifdef TF_UNITY_LANE0_EN
      return 64'h1;
`else
      return v;
`endif
   endfunction

   function automatic logic [255:0] exp_beat(input int idx);
      logic [255:0] r;
      for (int l = 0; l < 4; l++) r[l*64 +: 64] = tbl[(idx + 16*l) % 64];
      r[63:0] = lane0_of(r[63:0]);
      return r;
   endfunction

   task automatic clear_gates();
      cen_at = -1; cen_len = 0; stg_at = -1; stg_len = 0; we_at = -1;
   endtask

   // Start a run, optionally with a same-cycle table write, and check every cycle until done.
   task automatic run_and_check(input logic [5:0] s_idx, input logic [3:0] hl,
                                input logic [6:0] ni, input int exp_beats,
                                input logic sw_en, input logic [5:0] sw_addr,
                                input logic [63:0] sw_data, input string tag);
      int beats, cyc, b_idx;
      logic finished, gated;
      bus_if.start     = 1'b1;
      bus_if.start_idx = s_idx;
      bus_if.hold_len  = hl;
      bus_if.num_idx   = ni;
      bus_if.cfg_we    = sw_en;
      bus_if.cfg_addr  = sw_addr;
      bus_if.cfg_wdata = sw_data;
      if (sw_en) tbl[sw_addr] = sw_data;
      tick();
      bus_if.start  = 1'b0;
      bus_if.cfg_we = 1'b0;
      check({255'd0, bus_if.busy}, 256'd1, {tag, "_busy_start"});
      beats = 0; cyc = 0; finished = 1'b0;
      while (!finished && cyc < 400) begin
         bus_if.CEN = (cyc >= cen_at) && (cyc < cen_at + cen_len);
         bus_if.stage_counter = ((cyc >= stg_at) && (cyc < stg_at + stg_len)) ? 3'd2 : 3'd0;
         bus_if.cfg_we    = (cyc == we_at);
         bus_if.cfg_addr  = we_addr;
         bus_if.cfg_wdata = we_data;
         gated = bus_if.CEN || (bus_if.stage_counter != 3'd0);
         tick();
         cyc++;
         check({255'd0, bus_if.tf_valid}, {255'd0, !gated}, {tag, "_valid"});
         if (bus_if.tf_valid) begin
            b_idx = (s_idx + beats / (hl + 1)) % 64;
            check(bus_if.tf_data, exp_beat(b_idx), {tag, "_data"});
            got[beats % 128] = bus_if.tf_data;
            beats++;
            check({255'd0, bus_if.done}, {255'd0, beats == exp_beats}, {tag, "_done_pos"});
            if (bus_if.done) begin
               check({255'd0, bus_if.busy}, 256'd0, {tag, "_busy_end"});
               finished = 1'b1;
            end else if (beats >= exp_beats) begin
               finished = 1'b1;
            end
         end
      end
      check({255'd0, finished}, 256'd1, {tag, "_timeout"});
      check(256'(beats), 256'(exp_beats), {tag, "_beats"});
      clear_gates();
      bus_if.CEN = 1'b0; bus_if.stage_counter = 3'd0; bus_if.cfg_we = 1'b0;
      tick();
      check({253'd0, bus_if.busy, bus_if.tf_valid, bus_if.done}, 256'd0, {tag, "_idle_after"});
      check(bus_if.tf_data, got[(beats + 127) % 128], {tag, "_data_hold"});
   endtask

   initial begin
      checks = 0; errors = 0;
      clear_gates();
      we_addr = 6'd0; we_data = 64'd0;
      bus_if.cfg_we = 1'b0; bus_if.cfg_addr = 6'd0; bus_if.cfg_wdata = 64'd0;
      bus_if.start = 1'b0; bus_if.start_idx = 6'd0; bus_if.hold_len = 4'd0;
      bus_if.num_idx = 7'd0; bus_if.stage_counter = 3'd0; bus_if.CEN = 1'b0;
      for (int i = 0; i < 64; i++) tbl[i] = 64'd0;
      rst_n = 1'b0;
      tick(); tick();
      check({bus_if.tf_data[252:0], bus_if.busy, bus_if.tf_valid, bus_if.done}, 256'd0, "reset_outs");
      check(bus_if.tf_data, 256'd0, "reset_data");
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 64; i++) begin
         bus_if.cfg_we = 1'b1; bus_if.cfg_addr = 6'(i); bus_if.cfg_wdata = 64'(i + 256);
         tbl[i] = 64'(i + 256);
         tick();
      end
      bus_if.cfg_we = 1'b0;

      // Scenario 1: two indices held 16 beats each.
      run_and_check(6'd1, 4'd15, 7'd2, 32, 1'b0, 6'd0, 64'd0, "s1");
      check(got[0],  {64'h131, 64'h121, 64'h111, lane0_of(64'h101)}, "s1_beat1");
      check(got[15], {64'h131, 64'h121, 64'h111, lane0_of(64'h101)}, "s1_beat16");
      check(got[16], {64'h132, 64'h122, 64'h112, lane0_of(64'h102)}, "s1_beat17");
      check(got[31], {64'h132, 64'h122, 64'h112, lane0_of(64'h102)}, "s1_beat32");

      // Wrap of the base index and of the lane offsets.
      run_and_check(6'd63, 4'd0, 7'd2, 2, 1'b0, 6'd0, 64'd0, "wrap");
      check(got[0], {64'h12F, 64'h11F, 64'h10F, lane0_of(64'h13F)}, "wrap_beat1");
      check(got[1], {64'h130, 64'h120, 64'h110, lane0_of(64'h100)}, "wrap_beat2");

      // CEN and stage-mismatch gating mid-run.
      cen_at = 2; cen_len = 3; stg_at = 6; stg_len = 2;
      run_and_check(6'd5, 4'd1, 7'd3, 6, 1'b0, 6'd0, 64'd0, "gate");
      check(got[5], {64'h137, 64'h127, 64'h117, lane0_of(64'h107)}, "gate_last");

      // Full-table run; a write attempted mid-run must be dropped.
      we_at = 10; we_addr = 6'd16; we_data = 64'hDEAD;
      run_and_check(6'd0, 4'd0, 7'd0, 64, 1'b0, 6'd0, 64'd0, "full");
      run_and_check(6'd0, 4'd0, 7'd1, 1, 1'b0, 6'd0, 64'd0, "rerun");
      check({192'd0, got[0][127:64]}, 256'h110, "rerun_lane1_kept");

      // Asynchronous reset in the middle of a long run.
      bus_if.start = 1'b1; bus_if.start_idx = 6'd3; bus_if.hold_len = 4'd15; bus_if.num_idx = 7'd0;
      tick();
      bus_if.start = 1'b0;
      repeat (5) tick();
      check({255'd0, bus_if.tf_valid}, 256'd1, "rst_pre_valid");
      #2 rst_n = 1'b0;
      #1;
      check({253'd0, bus_if.busy, bus_if.tf_valid, bus_if.done}, 256'd0, "rst_async_ctl");
      check(bus_if.tf_data, 256'd0, "rst_async_data");
      for (int k = 0; k < 3; k++) begin
         tick();
         check({255'd0, bus_if.done}, 256'd0, "rst_no_done");
      end
      rst_n = 1'b1;
      for (int i = 0; i < 64; i++) tbl[i] = 64'd0;
      tick();

      // Fresh run after reset: cleared table, plus a same-cycle write with start.
      run_and_check(6'd0, 4'd0, 7'd1, 1, 1'b1, 6'd32, 64'h77, "fresh");
      check(got[0], {64'h0, 64'h77, 64'h0, lane0_of(64'h0)}, "fresh_beat");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tf_lane_seq_gen.md
Name: tf_lane_seq_gen

Overview:
Parametrised twiddle-factor sequencer for the radix-16 NTT datapath. It holds a runtime-loadable twiddle table and streams LANES factors per beat into the butterfly row multipliers. Each table index is held for a programmable number of beats, and the read pointer walks and wraps through the table. Advance is gated by chip enable and a selected stage, so one block serves any row or stage instead of a hard-coded, reset-loaded table.

Parameters:
P_WIDTH, 64, twiddle word width
DEPTH, 64, table entries; must be a power of two
ADDR_W, 6, log2(DEPTH)
LANES, 4, factors output per beat
LANE_STRIDE, 16, table-index offset between adjacent lanes
HOLD_W, 4, width of the hold-length field
SC_WIDTH, 3, stage_counter width
ACTIVE_STAGE, 0, stage_counter value on which the sequencer advances

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
cfg_we  in  1  table write strobe; honoured only in IDLE
cfg_addr  in  ADDR_W  table write address
cfg_wdata  in  P_WIDTH  table write data
start  in  1  single-cycle pulse; begins a run
start_idx  in  ADDR_W  first table index of the run
hold_len  in  HOLD_W  beats per index, minus 1
num_idx  in  ADDR_W+1  indices per run; 0 means DEPTH
stage_counter  in  SC_WIDTH  current pipeline stage
CEN  in  1  active-low enable
busy  out  1  high while state is RUN
tf_valid  out  1  tf_data carries a new beat
tf_data  out  LANES*P_WIDTH  lane l occupies bits [l*P_WIDTH +: P_WIDTH]
done  out  1  one-cycle pulse on the final beat of a run

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=IDLE; table, idx, cnt, rem, hold_q all cleared to 0.
  - busy=0, tf_valid=0, tf_data=0, done=0.
  - Reset mid-run aborts the run immediately; no done pulse is produced.
- Table write: when cfg_we=1 and state=IDLE, table[cfg_addr] is written at the clock edge. cfg_we in RUN is ignored and the table is unchanged.
- IDLE to RUN on start=1:
  - idx<=start_idx, cnt<=0, hold_q<=hold_len.
  - rem<=num_idx, with num_idx=0 loaded as DEPTH.
  - busy goes 1 on the next cycle.
  - start while in RUN is ignored.
- adv = (state==RUN) && !CEN && (stage_counter==ACTIVE_STAGE).
- On each adv cycle:
  - tf_data lane l <= table[(idx + l*LANE_STRIDE) mod DEPTH], taken by ADDR_W truncation.
  - tf_valid<=1. Latency is 1 cycle from the adv edge.
  - If cnt==hold_q: cnt<=0, idx<=idx+1 (wraps DEPTH-1 to 0), rem<=rem-1.
  - Otherwise: cnt<=cnt+1.
- Run end: on the adv cycle with cnt==hold_q and rem==1:
  - done<=1 in the same cycle tf_valid<=1 for that last beat.
  - state<=IDLE, so busy=0 from the following cycle.
- On non-adv cycles: tf_valid<=0, done<=0, tf_data holds its last value. CEN=1 or a stage mismatch freezes cnt, idx and rem.
- Same-cycle cfg_we and start in IDLE: both take effect. The write lands before any read, because the first read happens on the earliest next adv cycle.
- A run emits exactly num_idx*(hold_len+1) valid beats (DEPTH*(hold_len+1) when num_idx=0).

Optional Feature:
TF_UNITY_LANE0_EN
- Defined: lane 0 of tf_data is forced to P_WIDTH'h1 on every valid beat, regardless of table contents, for rows whose first butterfly input needs no twiddle. Lanes 1..LANES-1 are unchanged.
- Undefined: lane 0 reads the table like every other lane.

Test Plan:
- Reset, then write table[i]=i+0x100 for i=0..63. Start with start_idx=1, hold_len=15, num_idx=2, CEN=0, stage=0. Required: 32 valid beats. Beats 1-16 give lanes {0x101,0x111,0x121,0x131}; beats 17-32 give {0x102,0x112,0x122,0x132}. done on beat 32; busy=0 after.
- Wrap: start_idx=63, hold_len=0, num_idx=2. Required: lanes {0x13F,0x10F,0x11F,0x12F} then {0x100,0x110,0x120,0x130}.
- Gating: toggle CEN=1 for 3 cycles and set stage_counter=2 for 2 cycles mid-run. Required: no valid beats in those cycles, no index skip, total beat count unchanged.
- num_idx=0, hold_len=0. Required: exactly 64 beats and a single done pulse. cfg_we during the run leaves the table unchanged, checked by a rerun.
- Assert rst_n low mid-run. Required: all outputs 0 asynchronously, no done pulse, table cleared, a fresh start works.
- With TF_UNITY_LANE0_EN defined, repeat scenario 1. Required: lane 0 is 0x1 on every beat; other lanes match scenario 1.
